// File: rtl/plic_tl_arbiter.sv
// Two-requester TileLink-UL A-channel arbiter with in-order D-channel return routing (optional macro: PLIC_ARB_FIXED_PRIO_EN).
// Latency: zero added cycles on A and D paths; arbitration state updates on the rising clock edge.
// Backpressure: a full owner FIFO blocks all A grants; a stalled PLIC A handshake locks the grant; D stalls follow the owning requester's ready.
module plic_tl_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_a_valid,
    output logic        m0_a_ready,
    input  logic [2:0]  m0_a_bits_opcode,
    input  logic [2:0]  m0_a_bits_param,
    input  logic [1:0]  m0_a_bits_size,
    input  logic [10:0] m0_a_bits_source,
    input  logic [27:0] m0_a_bits_address,
    input  logic [7:0]  m0_a_bits_mask,
    input  logic [63:0] m0_a_bits_data,
    input  logic        m0_a_bits_corrupt,
    output logic        m0_d_valid,
    input  logic        m0_d_ready,
    output logic [2:0]  m0_d_bits_opcode,
    output logic [1:0]  m0_d_bits_size,
    output logic [10:0] m0_d_bits_source,
    output logic [63:0] m0_d_bits_data,

    input  logic        m1_a_valid,
    output logic        m1_a_ready,
    input  logic [2:0]  m1_a_bits_opcode,
    input  logic [2:0]  m1_a_bits_param,
    input  logic [1:0]  m1_a_bits_size,
    input  logic [10:0] m1_a_bits_source,
    input  logic [27:0] m1_a_bits_address,
    input  logic [7:0]  m1_a_bits_mask,
    input  logic [63:0] m1_a_bits_data,
    input  logic        m1_a_bits_corrupt,
    output logic        m1_d_valid,
    input  logic        m1_d_ready,
    output logic [2:0]  m1_d_bits_opcode,
    output logic [1:0]  m1_d_bits_size,
    output logic [10:0] m1_d_bits_source,
    output logic [63:0] m1_d_bits_data,

    output logic        s_a_valid,
    input  logic        s_a_ready,
    output logic [2:0]  s_a_bits_opcode,
    output logic [2:0]  s_a_bits_param,
    output logic [1:0]  s_a_bits_size,
    output logic [10:0] s_a_bits_source,
    output logic [27:0] s_a_bits_address,
    output logic [7:0]  s_a_bits_mask,
    output logic [63:0] s_a_bits_data,
    output logic        s_a_bits_corrupt,

    input  logic        s_d_valid,
    output logic        s_d_ready,
    input  logic [2:0]  s_d_bits_opcode,
    input  logic [1:0]  s_d_bits_size,
    input  logic [10:0] s_d_bits_source,
    input  logic [63:0] s_d_bits_data,

    output logic        err
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [10:0] source;
        logic [27:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
    } a_bits_t;

    a_bits_t m0_pay;
    a_bits_t m1_pay;
    a_bits_t s_pay;

    assign m0_pay = '{m0_a_bits_opcode, m0_a_bits_param, m0_a_bits_size, m0_a_bits_source,
                      m0_a_bits_address, m0_a_bits_mask, m0_a_bits_data, m0_a_bits_corrupt};
    assign m1_pay = '{m1_a_bits_opcode, m1_a_bits_param, m1_a_bits_size, m1_a_bits_source,
                      m1_a_bits_address, m1_a_bits_mask, m1_a_bits_data, m1_a_bits_corrupt};

    // Owner FIFO: one bit per in-flight request naming the requester that issued it.
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic                       lock_vld;
    logic                       lock_id;
    logic                       err_q;
`ifndef PLIC_ARB_FIXED_PRIO_EN
    logic                       rr;
`endif

    logic full;
    logic nonempty;
    logic grant;
    logic grant_valid;
    logic a_open;
    logic a_fire;
    logic owner;
    logic d_fire;

    // Pick the requester that drives the PLIC A channel this cycle.
    always_comb begin
        full     = (count == CW'(MAX_OUTSTANDING));
        nonempty = (count != '0);
        grant    = 1'b0;
        if (lock_vld) begin
            grant = lock_id;
        end else if (m0_a_valid && m1_a_valid) begin
`ifdef PLIC_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = rr;
`endif
        end else if (m1_a_valid) begin
            grant = 1'b1;
        end
        grant_valid = grant ? m1_a_valid : m0_a_valid;
    end

    // Reset gates the A side so no handshake is offered while held in reset.
    assign a_open     = reset && !full;
    assign s_a_valid  = grant_valid && a_open;
    assign s_pay      = grant ? m1_pay : m0_pay;
    assign m0_a_ready = !grant && s_a_ready && a_open;
    assign m1_a_ready =  grant && s_a_ready && a_open;
    assign a_fire     = s_a_valid && s_a_ready;

    assign s_a_bits_opcode  = s_pay.opcode;
    assign s_a_bits_param   = s_pay.param;
    assign s_a_bits_size    = s_pay.size;
    assign s_a_bits_source  = s_pay.source;
    assign s_a_bits_address = s_pay.address;
    assign s_a_bits_mask    = s_pay.mask;
    assign s_a_bits_data    = s_pay.data;
    assign s_a_bits_corrupt = s_pay.corrupt;

    // Responses return in order, so the FIFO head names the destination.
    assign owner      = owner_q[rd_ptr];
    assign m0_d_valid = s_d_valid && nonempty && !owner;
    assign m1_d_valid = s_d_valid && nonempty &&  owner;
    assign s_d_ready  = nonempty && (owner ? m1_d_ready : m0_d_ready);
    assign d_fire     = s_d_valid && s_d_ready;

    assign m0_d_bits_opcode = s_d_bits_opcode;
    assign m0_d_bits_size   = s_d_bits_size;
    assign m0_d_bits_source = s_d_bits_source;
    assign m0_d_bits_data   = s_d_bits_data;
    assign m1_d_bits_opcode = s_d_bits_opcode;
    assign m1_d_bits_size   = s_d_bits_size;
    assign m1_d_bits_source = s_d_bits_source;
    assign m1_d_bits_data   = s_d_bits_data;

    assign err = err_q;

    // Owner FIFO push on A fire, pop on D fire; count tells full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (a_fire) begin
                owner_q[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (d_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (a_fire && !d_fire) begin
                count <= count + CW'(1);
            end else if (!a_fire && d_fire) begin
                count <= count - CW'(1);
            end
        end
    end

    // Hold the grant on a stalled A handshake so the PLIC sees a stable request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_vld <= 1'b0;
            lock_id  <= 1'b0;
        end else if (a_fire) begin
            lock_vld <= 1'b0;
        end else if (s_a_valid) begin
            lock_vld <= 1'b1;
            lock_id  <= grant;
        end
    end

`ifndef PLIC_ARB_FIXED_PRIO_EN
    // After each accepted request the other requester gets priority in a contest.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr <= 1'b0;
        end else if (a_fire) begin
            rr <= !grant;
        end
    end
`endif

    // A response with nothing outstanding is a protocol error; it sticks until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (s_d_valid && !nonempty) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_plic_tl_arbiter.sv
module tb_plic_tl_arbiter;

    localparam int MAXO = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic         m0_a_valid = 1'b0, m1_a_valid = 1'b0;
    logic [119:0] m0_pay = '0, m1_pay = '0;
    logic         m0_d_ready = 1'b0, m1_d_ready = 1'b0;
    logic         s_a_ready = 1'b0;
    logic         s_d_valid = 1'b0;
    logic [79:0]  s_d_pay = '0;

    wire          m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid;
    wire          s_a_valid, s_d_ready, err;
    wire [2:0]    s_a_bits_opcode, s_a_bits_param;
    wire [1:0]    s_a_bits_size;
    wire [10:0]   s_a_bits_source;
    wire [27:0]   s_a_bits_address;
    wire [7:0]    s_a_bits_mask;
    wire [63:0]   s_a_bits_data;
    wire          s_a_bits_corrupt;
    wire [2:0]    m0_d_bits_opcode, m1_d_bits_opcode;
    wire [1:0]    m0_d_bits_size, m1_d_bits_size;
    wire [10:0]   m0_d_bits_source, m1_d_bits_source;
    wire [63:0]   m0_d_bits_data, m1_d_bits_data;

    plic_tl_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clock(clock), .reset(reset),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
        .m0_a_bits_opcode(m0_pay[119:117]), .m0_a_bits_param(m0_pay[116:114]),
        .m0_a_bits_size(m0_pay[113:112]), .m0_a_bits_source(m0_pay[111:101]),
        .m0_a_bits_address(m0_pay[100:73]), .m0_a_bits_mask(m0_pay[72:65]),
        .m0_a_bits_data(m0_pay[64:1]), .m0_a_bits_corrupt(m0_pay[0]),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
        .m0_d_bits_opcode(m0_d_bits_opcode), .m0_d_bits_size(m0_d_bits_size),
        .m0_d_bits_source(m0_d_bits_source), .m0_d_bits_data(m0_d_bits_data),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
        .m1_a_bits_opcode(m1_pay[119:117]), .m1_a_bits_param(m1_pay[116:114]),
        .m1_a_bits_size(m1_pay[113:112]), .m1_a_bits_source(m1_pay[111:101]),
        .m1_a_bits_address(m1_pay[100:73]), .m1_a_bits_mask(m1_pay[72:65]),
        .m1_a_bits_data(m1_pay[64:1]), .m1_a_bits_corrupt(m1_pay[0]),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
        .m1_d_bits_opcode(m1_d_bits_opcode), .m1_d_bits_size(m1_d_bits_size),
        .m1_d_bits_source(m1_d_bits_source), .m1_d_bits_data(m1_d_bits_data),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
        .s_a_bits_opcode(s_a_bits_opcode), .s_a_bits_param(s_a_bits_param),
        .s_a_bits_size(s_a_bits_size), .s_a_bits_source(s_a_bits_source),
        .s_a_bits_address(s_a_bits_address), .s_a_bits_mask(s_a_bits_mask),
        .s_a_bits_data(s_a_bits_data), .s_a_bits_corrupt(s_a_bits_corrupt),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
        .s_d_bits_opcode(s_d_pay[79:77]), .s_d_bits_size(s_d_pay[76:75]),
        .s_d_bits_source(s_d_pay[74:64]), .s_d_bits_data(s_d_pay[63:0]),
        .err(err)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: list of owners of outstanding requests, priority bit, held grant, error flag.
    int q[$];
    bit pri_m1;
    bit held;
    int held_id;
    bit err_m;
    int fires[$];
    bit mode_rand = 0;

    function automatic logic [119:0] rand_pay();
        logic [119:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        return p;
    endfunction

    function automatic logic [79:0] rand_dpay();
        logic [79:0] p;
        p = {$urandom, $urandom, $urandom};
        return p;
    endfunction

    function automatic void model_reset();
        q.delete();
        pri_m1  = 0;
        held    = 0;
        held_id = 0;
        err_m   = 0;
    endfunction

    // One clock cycle: entered 1 time unit after a rising edge with inputs already set.
    task automatic step();
        int  g;
        bit  v[2];
        bit  dr[2];
        bit  full, exp_sav, a_fire, d_fire, f0, f1;
        logic [119:0] sbits;
        #3;
        v[0] = m0_a_valid; v[1] = m1_a_valid;
        dr[0] = m0_d_ready; dr[1] = m1_d_ready;
        full = (q.size() == MAXO);
        if (held) g = held_id;
        else if (v[0] && v[1]) begin
`ifdef PLIC_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = pri_m1 ? 1 : 0;
`endif
        end else g = v[1] ? 1 : 0;
        exp_sav = v[g] && !full;
        check("s_a_valid", s_a_valid, exp_sav);
        check("m0_a_ready", m0_a_ready, (g == 0) && s_a_ready && !full);
        check("m1_a_ready", m1_a_ready, (g == 1) && s_a_ready && !full);
        if (exp_sav) begin
            sbits = {s_a_bits_opcode, s_a_bits_param, s_a_bits_size, s_a_bits_source,
                     s_a_bits_address, s_a_bits_mask, s_a_bits_data, s_a_bits_corrupt};
            check("s_a_bits", sbits, (g == 1) ? m1_pay : m0_pay);
        end
        if (q.size() > 0) begin
            check("m0_d_valid", m0_d_valid, s_d_valid && (q[0] == 0));
            check("m1_d_valid", m1_d_valid, s_d_valid && (q[0] == 1));
            check("s_d_ready", s_d_ready, dr[q[0]]);
            d_fire = s_d_valid && dr[q[0]];
        end else begin
            check("m0_d_valid_empty", m0_d_valid, 1'b0);
            check("m1_d_valid_empty", m1_d_valid, 1'b0);
            check("s_d_ready_empty", s_d_ready, 1'b0);
            d_fire = 0;
        end
        if (s_d_valid) begin
            check("m0_d_src", m0_d_bits_source, s_d_pay[74:64]);
            check("m1_d_data", m1_d_bits_data, s_d_pay[63:0]);
        end
        check("err", err, err_m);
        a_fire = exp_sav && s_a_ready;
        if (d_fire) void'(q.pop_front());
        if (s_d_valid && !full && q.size() == 0 && !d_fire) err_m = 1;
        if (a_fire) begin
            q.push_back(g);
            fires.push_back(g);
            pri_m1 = (g == 0);
            held = 0;
        end else if (exp_sav) begin
            held = 1;
            held_id = g;
        end
        f0 = a_fire && g == 0;
        f1 = a_fire && g == 1;
        @(posedge clock);
        #1;
        if (f0) m0_pay = rand_pay();
        if (f1) m1_pay = rand_pay();
        s_d_pay = rand_dpay();
        if (mode_rand) begin
            if (f0 || !m0_a_valid) m0_a_valid = $urandom_range(0, 1);
            if (f1 || !m1_a_valid) m1_a_valid = $urandom_range(0, 1);
            s_a_ready  = ($urandom_range(0, 3) != 0);
            m0_d_ready = ($urandom_range(0, 3) != 0);
            m1_d_ready = ($urandom_range(0, 3) != 0);
            s_d_valid  = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #3;
        check("rst_s_a_valid", s_a_valid, 1'b0);
        check("rst_m0_a_ready", m0_a_ready, 1'b0);
        check("rst_m1_a_ready", m1_a_ready, 1'b0);
        check("rst_m0_d_valid", m0_d_valid, 1'b0);
        check("rst_m1_d_valid", m1_d_valid, 1'b0);
        check("rst_s_d_ready", s_d_ready, 1'b0);
        check("rst_err", err, 1'b0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        m0_a_valid = 0; m1_a_valid = 0; s_a_ready = 0; s_d_valid = 0;
        m0_d_ready = 0; m1_d_ready = 0;
    endtask

    initial begin
        int base;
        m0_pay = rand_pay();
        m1_pay = rand_pay();
        @(posedge clock);
        #1;
        m0_a_valid = 1; m1_a_valid = 1; s_a_ready = 1; s_d_valid = 1;
        apply_reset();

        // Both requesters valid, PLIC answers the cycle after each request.
        fires.delete();
        m0_d_ready = 1; m1_d_ready = 1; s_d_valid = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            s_d_valid = (q.size() > 0);
        end
        for (int i = 0; i < 6; i++) begin
`ifdef PLIC_ARB_FIXED_PRIO_EN
            check($sformatf("grant_seq%0d", i), fires[i], 0);
`else
            check($sformatf("grant_seq%0d", i), fires[i], i % 2);
`endif
        end

        // Grant held on m0 through a stall while m1 arrives.
        idle_inputs();
        apply_reset();
        fires.delete();
        m0_a_valid = 1;
        step();
        m1_a_valid = 1;
        step();
        step();
        s_a_ready = 1;
        step();
        step();
        check("lock_fire_count", fires.size(), 2);
        check("lock_first", fires[0], 0);
        check("lock_second", fires[1], 1);

        // Fill the owner FIFO; a pop does not admit a new request in the same cycle.
        idle_inputs();
        apply_reset();
        fires.delete();
        m0_a_valid = 1; m1_a_valid = 1; s_a_ready = 1;
        for (int i = 0; i < MAXO + 1; i++) step();
        check("full_fires", fires.size(), MAXO);
        m0_d_ready = 1; m1_d_ready = 1; s_d_valid = 1;
        step();
        check("full_no_bypass", fires.size(), MAXO);
        s_d_valid = 0;
        step();
        check("full_after_pop", fires.size(), MAXO + 1);

        // Head owned by m1 with m1 not ready blocks the D channel.
        idle_inputs();
        apply_reset();
        m1_a_valid = 1; s_a_ready = 1;
        step();
        m1_a_valid = 0; s_d_valid = 1; m0_d_ready = 1; m1_d_ready = 0;
        for (int i = 0; i < 3; i++) step();
        base = q.size();
        check("head_m1_held", base, 1);
        m1_d_ready = 1;
        step();
        check("head_m1_popped", q.size(), 0);

        // Response with nothing outstanding, then reset in the middle of traffic.
        idle_inputs();
        s_d_valid = 1;
        step();
        s_d_valid = 0;
        step();
        check("err_sticky", err, 1'b1);
        step();
        m0_a_valid = 1; m1_a_valid = 1; s_a_ready = 1; m0_d_ready = 1;
        s_d_valid = 1;
        for (int i = 0; i < 3; i++) step();
        apply_reset();

        // Randomised traffic against the model.
        idle_inputs();
        mode_rand = 1;
        for (int i = 0; i < 3000; i++) step();
        mode_rand = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/plic_tl_arbiter.md
# plic_tl_arbiter

Two-requester TileLink-UL arbiter that shares the single slave port of the PLIC clock-sink domain between the core-side bus fragment (m0) and the debug/system-bus fragment (m1). Arbitrates the A channel, records which requester owns each in-flight request in an in-order owner FIFO, and steers D-channel responses back to that owner. Sits directly in front of the `auto_plic_in_*` port; all transactions are single-beat (size ≤ 3, 64-bit data).

## Interface
- `MAX_OUTSTANDING`, default 4: depth of the owner FIFO, i.e. the maximum number of in-flight A requests; power of two, ≥ 2.
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `m<i>_a_valid` in 1, i∈{0,1}: requester i A valid.
- `m<i>_a_ready` out 1: requester i A ready.
- `m<i>_a_bits_{opcode,param,size,source,address,mask,data,corrupt}` in 3/3/2/11/28/8/64/1: requester i A payload.
- `m<i>_d_valid` out 1: response valid to requester i.
- `m<i>_d_ready` in 1: requester i D ready.
- `m<i>_d_bits_{opcode,size,source,data}` out 3/2/11/64: response payload, broadcast to both requesters.
- `s_a_valid` out 1, `s_a_ready` in 1, `s_a_bits_*` out (same widths as m side): to PLIC A channel.
- `s_d_valid` in 1, `s_d_ready` out 1, `s_d_bits_{opcode,size,source,data}` in 3/2/11/64: from PLIC D channel.
- `err` out 1: sticky protocol-error flag.

## Operation
- State: owner FIFO (`MAX_OUTSTANDING` × 1 bit, wr/rd pointers, count 0..MAX_OUTSTANDING), round-robin pointer `rr` (1 bit), grant lock `lock_vld` + `lock_id`, `err`.
- Arbitration (when not full and not locked): if only one requester valid, grant it; if both, grant `rr`. Locked: grant `lock_id` regardless of other valids.
- `s_a_valid` = granted requester's valid & !full; `s_a_bits_*` = granted requester's payload, unmodified; `m<g>_a_ready` = `s_a_ready` & !full; non-granted requester's ready = 0.
- Lock: if `s_a_valid` & !`s_a_ready`, set `lock_vld`, `lock_id`=grant; clear on A fire. Guarantees valid/payload stability toward the PLIC.
- A fire (`s_a_valid & s_a_ready`): push grant id into FIFO; `rr` ← !grant.
- D routing: owner = FIFO head. `m<owner>_d_valid` = `s_d_valid` & count≠0; other requester's d_valid = 0; `s_d_ready` = `m<owner>_d_ready` & count≠0. D fire pops head.
- Full (count == MAX_OUTSTANDING): no A grant; no bypass even if a D pop occurs same cycle. Simultaneous push+pop when not full: count unchanged, both pointers advance.
- Pointer wrap-around: modulo MAX_OUTSTANDING; count distinguishes full from empty.
- `s_d_valid` while count==0: `s_d_ready`=0, `err` set (sticky until reset).
- Reset (any time, including mid-transaction): count=0, pointers=0, `rr`=0 (m0 favoured), `lock_vld`=0, `err`=0; all ready/valid outputs 0 while reset low. In-flight responses are lost; no recovery.

## Timing
- A path and D path combinational: zero added latency, no bubble between back-to-back fires.
- `err` asserts the cycle after the offending `s_d_valid`.
- Owner FIFO/`rr`/lock update on rising `clock`; outputs depend only on registered state plus current-cycle valids/readies (no valid-depends-on-ready loop on the m side).

## Configuration
- `PLIC_ARB_FIXED_PRIO_EN`: when defined, m0 always wins a contested unlocked grant and `rr` is not implemented; m1 can starve. When undefined, round-robin as above.

## Test plan
- Reset release, both valid continuously, `s_a_ready`=1, PLIC answers 1 cycle later → A grants alternate m0,m1,m0,…; each D routed to matching requester (source preserved).
- m0 valid, `s_a_ready`=0 for 3 cycles, m1 raises valid in cycle 2 → grant held on m0 until fire, then m1 granted next cycle.
- MAX_OUTSTANDING=4, PLIC withholds D → after 4 fires both a_ready=0; one D fire → fifth request accepted the following cycle, not the same cycle.
- Owner at head is m1 with `m1_d_ready`=0 → `s_d_ready`=0, `m0_d_valid`=0 until m1 accepts.
- `s_d_valid`=1 with count=0 → `s_d_ready`=0, `err`=1 next cycle and stays 1; assert reset low mid-burst → all outputs 0, count 0, `err` 0.
- With `PLIC_ARB_FIXED_PRIO_EN`, both valid continuously → m0 wins every grant.
